// File: rtl/raw2gray_pkg.sv
// Shared constants and helpers for the Bayer-to-grayscale 2x2 binning block.
package raw2gray_pkg;

  localparam int unsigned DW_DEF        = 12;
  localparam int unsigned IMG_WIDTH_DEF = 640;

  function automatic int unsigned col_w(input int unsigned img_width);
    return $clog2(img_width);
  endfunction

  function automatic int unsigned buf_depth(input int unsigned img_width);
    return img_width / 2;
  endfunction

  function automatic int unsigned pair_w(input int unsigned dw);
    return dw + 1;
  endfunction

  function automatic int unsigned total_w(input int unsigned dw);
    return dw + 2;
  endfunction

  localparam int unsigned COL_W     = col_w(IMG_WIDTH_DEF);
  localparam int unsigned BUF_DEPTH = buf_depth(IMG_WIDTH_DEF);
  localparam int unsigned PAIR_W    = pair_w(DW_DEF);
  localparam int unsigned TOTAL_W   = total_w(DW_DEF);

  typedef enum logic {
    RowEven = 1'b0,
    RowOdd  = 1'b1
  } row_par_e;

endpackage

// File: rtl/raw2gray_pair_linebuf.sv
// Simple dual-port line buffer holding even-row horizontal pair sums.
// Synchronous write; read data is registered and held until the next read.
module raw2gray_pair_linebuf #(
  parameter int unsigned Depth = 320,
  parameter int unsigned Width = 13,
  parameter int unsigned AddrW = 9
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] rdata_q, rdata_d;

  // Holding the read register across idle cycles keeps the pair valid over iDVAL gaps.
  always_comb begin
    rdata_d = rdata_q;
    if (re_i) begin
      rdata_d = mem_q[raddr_i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= rdata_d;
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/raw2gray.sv
// Raw Bayer (RGGB) to half-resolution grayscale by 2x2 averaging.
// Optional RAW2GRAY_ROUND_EN: round half up instead of truncating the average.
module raw2gray
  import raw2gray_pkg::*;
#(
  parameter int unsigned IMG_WIDTH = IMG_WIDTH_DEF,
  parameter int unsigned DW        = DW_DEF
) (
  input  logic          iCLK,
  input  logic          iRST,
  input  logic [DW-1:0] iDATA,
  input  logic          iDVAL,
  input  logic          iFVAL,
  output logic [DW-1:0] oDATA,
  output logic          oDVAL
);

  localparam int unsigned CW     = col_w(IMG_WIDTH);
  localparam int unsigned ADDR_W = CW - 1;
  localparam int unsigned DEPTH  = buf_depth(IMG_WIDTH);
  localparam int unsigned PW     = pair_w(DW);
  localparam int unsigned TW     = total_w(DW);

  logic [CW-1:0] col_q, col_d;
  row_par_e      row_q, row_d;
  logic [DW-1:0] prev_q, prev_d;
  logic [DW-1:0] data_q, data_d;
  logic          dval_q, dval_d;

  logic              accept;
  logic              col_odd;
  logic              col_last;
  logic [ADDR_W-1:0] buf_addr;
  logic              buf_we;
  logic              buf_re;
  logic [PW-1:0]     pair_sum;
  logic [PW-1:0]     buf_rdata;
  logic [TW-1:0]     total;
  logic [TW-1:0]     total_adj;
  logic [DW-1:0]     gray;

  assign accept   = iDVAL & iFVAL;
  assign col_odd  = col_q[0];
  assign col_last = (col_q == CW'(IMG_WIDTH - 1));
  assign buf_addr = col_q[CW-1:1];
  assign buf_we   = accept & (row_q == RowEven) & col_odd;
  assign buf_re   = accept & (row_q == RowOdd) & ~col_odd;
  assign pair_sum = PW'(prev_q) + PW'(iDATA);
  assign total    = TW'(buf_rdata) + TW'(prev_q) + TW'(iDATA);

`ifdef RAW2GRAY_ROUND_EN
  // 4*max + 2 still fits in DW+2 bits, so no saturation is needed.
  assign total_adj = total + TW'(2);
`else
  assign total_adj = total;
`endif

  assign gray = total_adj[TW-1:2];

  raw2gray_pair_linebuf #(
    .Depth (DEPTH),
    .Width (PW),
    .AddrW (ADDR_W)
  ) u_linebuf (
    .clk_i   (iCLK),
    .we_i    (buf_we),
    .waddr_i (buf_addr),
    .wdata_i (pair_sum),
    .re_i    (buf_re),
    .raddr_i (buf_addr),
    .rdata_o (buf_rdata)
  );

  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    prev_d = prev_q;
    data_d = data_q;
    dval_d = 1'b0;
    if (!iFVAL) begin
      col_d  = '0;
      row_d  = RowEven;
      prev_d = '0;
    end else if (iDVAL) begin
      prev_d = iDATA;
      if (col_last) begin
        col_d = '0;
        row_d = (row_q == RowEven) ? RowOdd : RowEven;
      end else begin
        col_d = col_q + CW'(1);
      end
      if ((row_q == RowOdd) && col_odd) begin
        dval_d = 1'b1;
        data_d = gray;
      end
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      col_q  <= '0;
      row_q  <= RowEven;
      prev_q <= '0;
      data_q <= '0;
      dval_q <= 1'b0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      prev_q <= prev_d;
      data_q <= data_d;
      dval_q <= dval_d;
    end
  end

  assign oDATA = data_q;
  assign oDVAL = dval_q;

endmodule
